// File: rtl/sram_ctrl_pkg.sv
// Shared types and pin constants for the SRAM macro controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_ctrl_pkg;

    // Power sequencing states; the encoding is visible on the pwr_state port.
    typedef enum logic [1:0] {
        PWR_ACTIVE   = 2'd0,
        PWR_SLEEP    = 2'd1,
        PWR_SHUTDOWN = 2'd2,
        PWR_WAKE     = 2'd3
    } pwr_state_e;

    // Macro pin levels that leave the array untouched (all controls active-low).
    localparam logic CEB_OFF      = 1'b1;
    localparam logic WEB_OFF      = 1'b1;
    localparam logic BWEB_OFF_BIT = 1'b1;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO with valid/ready drain side and occupancy count.
// Latency: a push at edge E is visible on pop_vld/pop_dat in the cycle after E.
// Backpressure: pop_rdy low holds the head; upstream must respect count (no full flag).
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             push_ok;

    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];
    assign pop     = pop_vld && pop_rdy;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_macro_ctrl.sv
// Request-side controller for a 256x32 single-port SRAM macro with SLP/SD sequencing.
// Latency: read accepted at edge T -> Q captured at T+1+RD_LAT -> rsp_valid after T+2 (RD_LAT=1).
// Backpressure: req_ready drops when reads in flight plus queued responses reach RSP_DEPTH.
module sram_macro_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4,
    parameter int IDLE_SLP  = 16,
    parameter int WAKE_CYC  = 2
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_bmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              sleep_en,
    input  logic              sd_req,
    output logic [1:0]        pwr_state,
    output logic              CEB,
    output logic              WEB,
    output logic              SLP,
    output logic              SD,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] BWEB,
    output logic              BIST,
    output logic              AWT,
    input  logic [DATA_W-1:0] Q
);

    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int CRED_W = $clog2(RSP_DEPTH + RD_LAT + 2);
    localparam int IDLE_W = $clog2(IDLE_SLP + 1);
    localparam int WAKE_W = $clog2(WAKE_CYC + 1);
    localparam logic [DATA_W-1:0] BWEB_OFF = {DATA_W{BWEB_OFF_BIT}};

    pwr_state_e        state_q;
    pwr_state_e        state_d;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_d;
    logic [WAKE_W-1:0] wake_cnt_q;
    logic [WAKE_W-1:0] wake_cnt_d;
    logic [RD_LAT:0]   rd_tag_q;
    logic [CRED_W-1:0] inflight;
    logic [CRED_W-1:0] credit_used;
    logic [CNT_W-1:0]  fifo_count;
    logic              accept;
    logic              accept_rd;
    logic              idle_cyc;
    logic              fifo_push;

    assign BIST      = 1'b0;
    assign AWT       = 1'b0;
    assign pwr_state = state_q;

    // Reads in flight: every tag still travelling toward the Q capture edge.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + CRED_W'(rd_tag_q[i]);
        end
    end

    assign credit_used = inflight + CRED_W'(fifo_count);
    assign req_ready   = (state_q == PWR_ACTIVE) && (credit_used < CRED_W'(RSP_DEPTH)) && !sd_req;
    assign accept      = req_valid && req_ready;
    assign accept_rd   = accept && !req_we;
    assign idle_cyc    = !accept && (inflight == '0) && sleep_en;
    // Tag in the last stage means Q holds that read's word at the coming edge.
    assign fifo_push   = rd_tag_q[RD_LAT];

    // Read-tag shift register: stage 0 is the pin-register edge, stage RD_LAT the capture edge.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            rd_tag_q <= '0;
        end else begin
            rd_tag_q[0] <= accept_rd;
            for (int i = 1; i <= RD_LAT; i++) begin
                rd_tag_q[i] <= rd_tag_q[i-1];
            end
        end
    end

    // Power state, idle counter and wake counter registers.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q    <= PWR_ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // Power sequencing: shutdown beats sleep; sleep is entered on the edge the counter hits its limit.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        case (state_q)
            PWR_ACTIVE: begin
                idle_cnt_d = idle_cyc ? idle_cnt_q + 1'b1 : '0;
                if (sd_req && (inflight == '0)) begin
                    state_d = PWR_SHUTDOWN;
                end else if (idle_cyc && (idle_cnt_d == IDLE_W'(IDLE_SLP - 1))) begin
                    state_d = PWR_SLEEP;
                end
            end
            PWR_SLEEP: begin
                idle_cnt_d = idle_cnt_q;
                if (sd_req) begin
                    state_d = PWR_SHUTDOWN;
                end else if (req_valid || !sleep_en) begin
                    state_d = PWR_WAKE;
                end
            end
            PWR_SHUTDOWN: begin
                if (!sd_req) begin
                    state_d = PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                if (wake_cnt_q == WAKE_W'(WAKE_CYC - 1)) begin
                    state_d = PWR_ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: state_d = PWR_ACTIVE;
        endcase
    end

    // Registered macro pins; A and D keep their last values between accesses.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            CEB  <= CEB_OFF;
            WEB  <= WEB_OFF;
            BWEB <= BWEB_OFF;
            A    <= '0;
            D    <= '0;
            SLP  <= 1'b0;
            SD   <= 1'b0;
        end else begin
            if (accept) begin
                CEB  <= 1'b0;
                WEB  <= ~req_we;
                A    <= req_addr;
                D    <= req_wdata;
                BWEB <= req_we ? ~req_bmask : BWEB_OFF;
            end else begin
                CEB  <= CEB_OFF;
                WEB  <= WEB_OFF;
                BWEB <= BWEB_OFF;
            end
            SLP <= (state_d == PWR_SLEEP);
            SD  <= (state_d == PWR_SHUTDOWN);
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk      (CLK),
        .rst_n    (RSTB),
        .push     (fifo_push),
        .push_dat (Q),
        .pop_vld  (rsp_valid),
        .pop_rdy  (rsp_ready),
        .pop_dat  (rsp_rdata),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_sram_macro_ctrl.sv
// Directed bench for sram_macro_ctrl with a behavioural macro model and response scoreboard.
// Latency: checks 2-cycle read latency, credit stall/return and wake timing.
// Backpressure: drives rsp_ready low to exercise the credit limit.
module tb_sram_macro_ctrl;

    logic        CLK;
    logic        RSTB;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_bmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        sleep_en;
    logic        sd_req;
    logic [1:0]  pwr_state;
    logic        CEB, WEB, SLP, SD, BIST, AWT;
    logic [7:0]  A;
    logic [31:0] D, BWEB, Q;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] bp_exp[6];
    logic [31:0] mem[256];

    sram_macro_ctrl dut (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_bmask (req_bmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sleep_en  (sleep_en),
        .sd_req    (sd_req),
        .pwr_state (pwr_state),
        .CEB       (CEB),
        .WEB       (WEB),
        .SLP       (SLP),
        .SD        (SD),
        .A         (A),
        .D         (D),
        .BWEB      (BWEB),
        .BIST      (BIST),
        .AWT       (AWT),
        .Q         (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural macro: samples pins on the rising edge, Q valid one cycle later.
    initial Q = '0;
    always @(posedge CLK) begin
        if (!CEB) begin
            if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
            else      Q      <= mem[A];
        end
    end

    // Response monitor: pops the scoreboard whenever a response handshake is presented.
    always @(negedge CLK) begin
        if (RSTB && rsp_valid && rsp_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_spurious: got %h, none expected", rsp_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rsp_rdata !== mon_exp) begin
                    bad++;
                    $display("FAIL rsp_data: got %h want %h", rsp_rdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_CEB"}, 32'(CEB), 32'd1);
        check({tag, "_WEB"}, 32'(WEB), 32'd1);
        check({tag, "_BWEB"}, BWEB, 32'hFFFF_FFFF);
        check({tag, "_A"}, 32'(A), 32'd0);
        check({tag, "_D"}, D, 32'd0);
        check({tag, "_SLP_SD"}, {30'd0, SLP, SD}, 32'd0);
        check({tag, "_BIST_AWT"}, {30'd0, BIST, AWT}, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_pwr"}, 32'(pwr_state), 32'd0);
    endtask

    // Presents one request, waits (bounded) for acceptance, and books any read response.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] bm, input logic [31:0] exp_rd);
        int n = 0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_bmask = bm;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge CLK); #1; n++;
        end
        check("issue_ready", 32'(req_ready), 32'd1);
        if (req_ready) begin
            @(posedge CLK);
            if (!we) exp_q.push_back(exp_rd);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
            @(negedge CLK); n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int nacc;
        int n;
        logic acc;
        for (int i = 0; i < 5; i++) bp_exp[i] = 32'hA000_0000 + 32'(i);
        bp_exp[5] = 32'hFFFF_0000;

        RSTB = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_bmask = '0; rsp_ready = 1'b1; sleep_en = 1'b0; sd_req = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_pins("rst");
        RSTB = 1'b1;
        #1 check("rst_req_ready", 32'(req_ready), 32'd1);

        // Full-mask write, pin encoding, then pins return to inactive with A/D held.
        issue(1'b1, 8'h19, 32'h0000_0056, 32'hFFFF_FFFF, '0);
        check("wr_CEB", 32'(CEB), 32'd0);
        check("wr_WEB", 32'(WEB), 32'd0);
        check("wr_A", 32'(A), 32'h19);
        check("wr_D", D, 32'h56);
        check("wr_BWEB", BWEB, 32'd0);
        @(posedge CLK); #1;
        check("idle_CEB_WEB", {30'd0, CEB, WEB}, 32'd3);
        check("idle_BWEB", BWEB, 32'hFFFF_FFFF);
        check("idle_A_hold", 32'(A), 32'h19);

        // Read back with 2-cycle latency.
        issue(1'b0, 8'h19, 32'h0, 32'h0, 32'h0000_0056);
        check("rd_pins", {29'd0, CEB, WEB, 1'b0}, 32'd2);
        check("rd_BWEB", BWEB, 32'hFFFF_FFFF);
        @(posedge CLK); @(negedge CLK);
        check("rd_lat_t1", 32'(rsp_valid), 32'd0);
        @(posedge CLK); @(negedge CLK);
        check("rd_lat_t2", 32'(rsp_valid), 32'd1);
        drain();

        // Partial write clears the low half only.
        issue(1'b1, 8'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
        issue(1'b1, 8'h05, 32'h0000_0000, 32'h0000_FFFF, '0);
        check("pw_BWEB", BWEB, 32'hFFFF_0000);
        issue(1'b0, 8'h05, 32'h0, 32'h0, 32'hFFFF_0000);
        drain();

        // Backpressure: six back-to-back reads against four credits.
        for (int i = 0; i < 5; i++) issue(1'b1, 8'(i), 32'hA000_0000 + 32'(i), 32'hFFFF_FFFF, '0);
        @(posedge CLK); #1 rsp_ready = 1'b0;
        @(negedge CLK);
        nacc = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd0;
        #1;
        for (int c = 0; c < 10; c++) begin
            acc = req_ready && req_valid;
            @(posedge CLK);
            if (acc) begin exp_q.push_back(bp_exp[nacc]); nacc++; end
            @(negedge CLK);
            req_addr = 8'(nacc);
            #1;
        end
        check("bp_accepted", 32'(nacc), 32'd4);
        check("bp_stall", 32'(req_ready), 32'd0);
        @(posedge CLK); #1 rsp_ready = 1'b1;
        @(negedge CLK); #1;
        check("bp_before_pop", 32'(req_ready), 32'd0);
        @(posedge CLK); @(negedge CLK); #1;
        check("bp_credit_return", 32'(req_ready), 32'd1);
        for (int c = 0; c < 20 && nacc < 6; c++) begin
            acc = req_ready && req_valid;
            @(posedge CLK);
            if (acc) begin exp_q.push_back(bp_exp[nacc]); nacc++; end
            @(negedge CLK);
            req_addr = 8'(nacc);
            if (nacc == 6) req_valid = 1'b0;
            #1;
        end
        req_valid = 1'b0;
        check("bp_all_accepted", 32'(nacc), 32'd6);
        drain();

        // Idle sleep: SLP rises on the 15th idle edge (counter reaches IDLE_SLP-1).
        sleep_en = 1'b1;
        repeat (14) @(posedge CLK);
        @(negedge CLK);
        check("slp_early", {30'd0, SLP, pwr_state == 2'd1}, 32'd0);
        @(posedge CLK); @(negedge CLK); #1;
        check("slp_SLP", 32'(SLP), 32'd1);
        check("slp_pwr", 32'(pwr_state), 32'd1);
        check("slp_CEB", 32'(CEB), 32'd1);
        check("slp_ready", 32'(req_ready), 32'd0);
        repeat (3) @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h19;
        #1 check("slp_hold_ready", 32'(req_ready), 32'd0);
        @(posedge CLK); @(negedge CLK); #1;
        check("wake_SLP", {30'd0, SLP, SD}, 32'd0);
        check("wake_pwr", 32'(pwr_state), 32'd3);
        n = 1;
        while (!req_ready && n < 10) begin
            @(posedge CLK); @(negedge CLK); #1; n++;
        end
        check("wake_cycles", 32'(n), 32'd3);
        if (req_ready) begin
            @(posedge CLK);
            exp_q.push_back(32'h0000_0056);
        end
        #1 req_valid = 1'b0; sleep_en = 1'b0;
        drain();

        // Shutdown and wake back to ACTIVE.
        sd_req = 1'b1;
        #1 check("sd_ready", 32'(req_ready), 32'd0);
        @(posedge CLK); @(negedge CLK);
        check("sd_pwr", 32'(pwr_state), 32'd2);
        check("sd_pins", {29'd0, SD, SLP, CEB}, 32'd5);
        sd_req = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("sd_wake", {29'd0, pwr_state, SD}, 32'd6);
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        check("sd_active", {29'd0, pwr_state, req_ready}, 32'd1);

        // Reset one cycle after a read is accepted: no response may appear.
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h19;
        #1 check("rst_rd_ready", 32'(req_ready), 32'd1);
        @(posedge CLK); #1 req_valid = 1'b0;
        @(posedge CLK); #1 RSTB = 1'b0;
        @(negedge CLK);
        check_reset_pins("midrst");
        @(negedge CLK); RSTB = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
